// File: rtl/mod_class_pkg.sv
// Purpose : shared state encodings, width helpers and constants for mod_class_fsm.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package mod_class_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ZERO    = 2'd1,
    S_NONZERO = 2'd2
  } state_e;

  localparam logic [15:0] ZT_MAX = 16'hFFFF;

  // Residue width: enough bits for 0..m-1, never less than one bit.
  function automatic int calc_rw(input int m);
    int w;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Run-counter width: enough bits to hold 0..n inclusive.
  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mod_reduce.sv
// Purpose : combinational reduction of an unsigned word modulo MOD.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; output follows input every cycle.
// Ports   : a [WIDTH-1:0] in, r [RW-1:0] out (a mod MOD).
// MAX_IN is the largest value a can carry. When it is below 2*MOD the
// reduction collapses to one compare and conditional subtract, which is how
// the modular accumulator adder uses this block.
module mod_reduce
  import mod_class_pkg::*;
#(
  parameter int  WIDTH  = 4,
  parameter int  MOD    = 2,
  parameter int  MAX_IN = (1 << WIDTH) - 1,
  localparam int RW     = calc_rw(MOD)
) (
  input  logic [WIDTH-1:0] a,
  output logic [RW-1:0]    r
);

  generate
    if (MAX_IN < MOD) begin : g_pass
      assign r = RW'(a);
    end else if (MAX_IN < 2 * MOD) begin : g_sub
      always_comb begin
        r = RW'(a);
        if (32'(a) >= 32'(MOD)) begin
          r = RW'(32'(a) - 32'(MOD));
        end
      end
    end else begin : g_mod
      assign r = RW'(32'(a) % 32'(MOD));
    end
  endgenerate

endmodule

// File: rtl/mod_class_fsm.sv
// Purpose : classifies accepted words by residue mod MOD (per-word or running sum),
//           tracks runs of zero residues; optional zero count under MOD_CLASS_CNT_EN.
// Latency : 1 cycle from accepted sample to registered outputs; out_valid pulses once.
// Backpr. : none; every in_valid without clear is accepted, clear wins and drops it.
// Ports   : clk, reset (async active-low), in_valid/a/mode/clear in;
//           out_valid, residue, is_zero, run_cnt, run_hit
//           [, zero_total when MOD_CLASS_CNT_EN is defined] out.
module mod_class_fsm
  import mod_class_pkg::*;
#(
  parameter int  WIDTH   = 4,
  parameter int  MOD     = 2,
  parameter int  RUN_LEN = 3,
  localparam int RW      = calc_rw(MOD),
  localparam int CW      = calc_cw(RUN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  input  logic             clear,
  output logic             out_valid,
  output logic [RW-1:0]    residue,
  output logic             is_zero,
  output logic [CW-1:0]    run_cnt,
  output logic             run_hit
`ifdef MOD_CLASS_CNT_EN
  ,
  output logic [15:0]      zero_total
`endif
);

  state_e        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d;
  logic          is_zero_q, is_zero_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          run_hit_q, run_hit_d;
  logic          out_valid_q, out_valid_d;

  logic [RW-1:0] r_word;
  logic [RW-1:0] acc_base;
  logic [RW:0]   sum;
  logic [RW-1:0] sum_red;
  logic [RW-1:0] new_acc;
  logic          new_zero;

  mod_reduce #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_reduce_word (
    .a (a),
    .r (r_word)
  );

  // Both addends are below MOD, so the sum is below 2*MOD and a single
  // conditional subtract finishes the modular add.
  mod_reduce #(
    .WIDTH  (RW + 1),
    .MOD    (MOD),
    .MAX_IN (2 * MOD - 2)
  ) u_reduce_sum (
    .a (sum),
    .r (sum_red)
  );

  // From idle, accumulation always starts at zero.
  assign acc_base = (state_q == S_IDLE) ? '0 : acc_q;
  assign sum      = {1'b0, acc_base} + {1'b0, r_word};
  assign new_acc  = mode ? sum_red : r_word;
  assign new_zero = (new_acc == '0);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    is_zero_d   = is_zero_q;
    run_cnt_d   = run_cnt_q;
    run_hit_d   = run_hit_q;
    out_valid_d = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      is_zero_d = 1'b1;
      run_cnt_d = '0;
      run_hit_d = 1'b0;
    end else if (in_valid) begin
      state_d     = new_zero ? S_ZERO : S_NONZERO;
      acc_d       = new_acc;
      is_zero_d   = new_zero;
      out_valid_d = 1'b1;
      if (!new_zero) begin
        run_cnt_d = '0;
      end else if (run_cnt_q != CW'(RUN_LEN)) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
      run_hit_d = (run_cnt_d == CW'(RUN_LEN));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      is_zero_q   <= 1'b1;
      run_cnt_q   <= '0;
      run_hit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      is_zero_q   <= is_zero_d;
      run_cnt_q   <= run_cnt_d;
      run_hit_q   <= run_hit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign residue   = acc_q;
  assign is_zero   = is_zero_q;
  assign run_cnt   = run_cnt_q;
  assign run_hit   = run_hit_q;

`ifdef MOD_CLASS_CNT_EN
  logic [15:0] zero_total_q, zero_total_d;

  always_comb begin
    zero_total_d = zero_total_q;
    if (clear) begin
      zero_total_d = '0;
    end else if (in_valid && new_zero && (zero_total_q != ZT_MAX)) begin
      zero_total_d = zero_total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_total_q <= '0;
    end else begin
      zero_total_q <= zero_total_d;
    end
  end

  assign zero_total = zero_total_q;
`endif

endmodule

// File: tb/tb_mod_class_fsm.sv
// Purpose : directed check of mod_class_fsm with MOD=2 and MOD=3 instances on shared stimulus.
// Latency : checks sampled 1 time unit after the rising edge that registers each sample.
// Backpr. : none; the DUT accepts every cycle.
module tb_mod_class_fsm;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] a;
  logic       mode;
  logic       clear;

  logic       ov2, iz2, hit2;
  logic [0:0] res2;
  logic [1:0] rc2;
  logic       ov3, iz3, hit3;
  logic [1:0] res3;
  logic [1:0] rc3;
`ifdef MOD_CLASS_CNT_EN
  logic [15:0] zt2, zt3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mod_class_fsm #(.WIDTH(4), .MOD(2), .RUN_LEN(3)) u_mod2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .mode      (mode),
    .clear     (clear),
    .out_valid (ov2),
    .residue   (res2),
    .is_zero   (iz2),
    .run_cnt   (rc2),
    .run_hit   (hit2)
`ifdef MOD_CLASS_CNT_EN
    ,
    .zero_total(zt2)
`endif
  );

  mod_class_fsm #(.WIDTH(4), .MOD(3), .RUN_LEN(3)) u_mod3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .mode      (mode),
    .clear     (clear),
    .out_valid (ov3),
    .residue   (res3),
    .is_zero   (iz3),
    .run_cnt   (rc3),
    .run_hit   (hit3)
`ifdef MOD_CLASS_CNT_EN
    ,
    .zero_total(zt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic drive(input logic v, input logic [3:0] av, input logic m, input logic c);
    @(negedge clk);
    in_valid = v;
    a        = av;
    mode     = m;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    a        = 4'd7;
    mode     = 1'b0;
    clear    = 1'b0;

    // Held in reset while a valid sample is presented.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov2",  32'(ov2),  0);
    chk("rst_res2", 32'(res2), 0);
    chk("rst_iz2",  32'(iz2),  1);
    chk("rst_rc2",  32'(rc2),  0);
    chk("rst_hit2", 32'(hit2), 0);
    chk("rst_res3", 32'(res3), 0);
    chk("rst_ov3",  32'(ov3),  0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;

    // Per-word parity: 6, 9, 4.
    drive(1, 4'd6, 0, 0);
    chk("pw6_iz2", 32'(iz2), 1);
    chk("pw6_ov2", 32'(ov2), 1);
    chk("pw6_rc2", 32'(rc2), 1);
    chk("pw6_res3", 32'(res3), 0);
    drive(1, 4'd9, 0, 0);
    chk("pw9_iz2", 32'(iz2), 0);
    chk("pw9_ov2", 32'(ov2), 1);
    chk("pw9_rc2", 32'(rc2), 0);
    chk("pw9_rc3", 32'(rc3), 2);
    drive(1, 4'd4, 0, 0);
    chk("pw4_iz2", 32'(iz2), 1);
    chk("pw4_ov2", 32'(ov2), 1);
    chk("pw4_res3", 32'(res3), 1);
    chk("pw4_rc3", 32'(rc3), 0);

    // Clear, then running accumulate 4, 5, 6.
    drive(0, 4'd0, 0, 1);
    chk("clr_res3", 32'(res3), 0);
    chk("clr_iz3",  32'(iz3),  1);
    chk("clr_ov3",  32'(ov3),  0);
    chk("clr_rc3",  32'(rc3),  0);
    drive(1, 4'd4, 1, 0);
    chk("acc4_res3", 32'(res3), 1);
    chk("acc4_rc3",  32'(rc3),  0);
    chk("acc4_res2", 32'(res2), 0);
    drive(1, 4'd5, 1, 0);
    chk("acc5_res3", 32'(res3), 0);
    chk("acc5_rc3",  32'(rc3),  1);
    chk("acc5_res2", 32'(res2), 1);
    drive(1, 4'd6, 1, 0);
    chk("acc6_res3", 32'(res3), 0);
    chk("acc6_rc3",  32'(rc3),  2);
    chk("acc6_hit3", 32'(hit3), 0);
    chk("acc6_res2", 32'(res2), 1);

    // Zero-run saturation: 2, 4, 6, 8, idle, 3.
    drive(0, 4'd0, 0, 1);
    drive(1, 4'd2, 0, 0);
    chk("run2_rc2",  32'(rc2),  1);
    chk("run2_hit2", 32'(hit2), 0);
    drive(1, 4'd4, 0, 0);
    chk("run4_rc2",  32'(rc2),  2);
    chk("run4_hit2", 32'(hit2), 0);
    drive(1, 4'd6, 0, 0);
    chk("run6_rc2",  32'(rc2),  3);
    chk("run6_hit2", 32'(hit2), 1);
    drive(1, 4'd8, 0, 0);
    chk("run8_rc2",  32'(rc2),  3);
    chk("run8_hit2", 32'(hit2), 1);
    drive(0, 4'd0, 0, 0);
    chk("idle_ov2",  32'(ov2),  0);
    chk("idle_rc2",  32'(rc2),  3);
    chk("idle_hit2", 32'(hit2), 1);
    chk("idle_iz2",  32'(iz2),  1);
    drive(1, 4'd3, 0, 0);
    chk("run3_rc2",  32'(rc2),  0);
    chk("run3_hit2", 32'(hit2), 0);
    chk("run3_iz2",  32'(iz2),  0);

    // Clear beats a simultaneous sample.
    drive(0, 4'd0, 0, 1);
    drive(1, 4'd2, 1, 0);
    chk("pre_res3", 32'(res3), 2);
    drive(1, 4'd5, 1, 1);
    chk("cw_res3", 32'(res3), 0);
    chk("cw_ov3",  32'(ov3),  0);
    chk("cw_iz3",  32'(iz3),  1);
    chk("cw_rc3",  32'(rc3),  0);
    drive(1, 4'd1, 1, 0);
    chk("cw1_res3", 32'(res3), 1);
    chk("cw1_ov3",  32'(ov3),  1);

    // Asynchronous reset mid-stream, then restart from idle.
    drive(1, 4'd1, 1, 0);
    chk("mid_res3", 32'(res3), 2);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd7;
    mode     = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_res3", 32'(res3), 0);
    chk("arst_ov3",  32'(ov3),  0);
    chk("arst_iz3",  32'(iz3),  1);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    drive(1, 4'd1, 1, 0);
    chk("post_res3", 32'(res3), 1);

    // Mode switch: per-word discards the sum, accumulation resumes from it.
    drive(1, 4'd5, 0, 0);
    chk("sw5_res3", 32'(res3), 2);
    drive(1, 4'd2, 1, 0);
    chk("sw2_res3", 32'(res3), 1);
    chk("sw2_iz3",  32'(iz3),  0);

`ifdef MOD_CLASS_CNT_EN
    begin
      logic [3:0] seq [7];
      seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      drive(0, 4'd0, 0, 1);
      chk("zt_clr2", 32'(zt2), 0);
      for (int i = 0; i < 7; i++) drive(1, seq[i], 0, 0);
      chk("zt_cnt2", 32'(zt2), 4);
      chk("zt_cnt3", 32'(zt3), 2);
      for (int i = 0; i < 65531; i++) drive(1, 4'd0, 0, 0);
      chk("zt_full2", 32'(zt2), 32'hFFFF);
      for (int i = 0; i < 3; i++) drive(1, 4'd0, 0, 0);
      chk("zt_sat2", 32'(zt2), 32'hFFFF);
    end
`endif

    drive(0, 4'd0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
